ladybird_uart_loader: RTL and testbench

Hardware boot loader: receives a program image from a host over an 8N1 UART line and issues it as word writes on a `ladybird_bus` initiator port, typically into instruction RAM through the bus arbitrator. It is the receiving end of the host program-download protocol. It holds the core in reset until the image is fully written, then releases it. It is placed beside the core in `ladybird_top`, sharing the IRAM arbitrator with the core instruction bus.

---
 rtl/ladybird_uart_loader.sv | 151 +++++++++++++++
 tb/tb_ladybird_uart_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_uart_loader.sv
// UART (8N1) boot loader: receives a length-prefixed word image and writes it over the
// bus, holding the core in reset until done. LADYBIRD_LOADER_CSUM_EN adds a trailing checksum byte.
module ladybird_uart_loader #(
  parameter logic [15:0] WTIME     = 16'h364,
  parameter int          N_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        anrst,
  input  logic        uart_txd_in,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  output logic        core_nrst,
  output logic        done,
  output logic        error
);
  typedef enum logic [1:0] {R_IDLE, R_START, R_BITS, R_STOP} rx_st_t;
  typedef enum logic [2:0] {S_LEN, S_DATA, S_DRAIN, S_CSUM, S_DONE, S_ERROR} ld_st_t;

  rx_st_t      rx_st, rx_nx;
  logic        rx_s1, rx_s2, rx_d;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh, rx_byte;
  logic        rx_vld, rx_ferr;
  logic        tick_half, tick_full;

  assign tick_half = (rx_cnt == (WTIME >> 1) - 16'd1);
  assign tick_full = (rx_cnt == WTIME - 16'd1);

  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      R_IDLE:  if (rx_d && !rx_s2) rx_nx = R_START;
      R_START: if (tick_half) rx_nx = rx_s2 ? R_IDLE : R_BITS;
      R_BITS:  if (tick_full && rx_bit == 3'd7) rx_nx = R_STOP;
      R_STOP:  if (tick_full) rx_nx = R_IDLE;
      default: rx_nx = R_IDLE;
    endcase
  end

  // Synchronizer flops reset high so the idle line never looks like a start edge.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_d <= 1'b1;
      rx_st <= R_IDLE; rx_cnt <= '0; rx_bit <= '0;
      rx_sh <= '0; rx_byte <= '0; rx_vld <= 1'b0; rx_ferr <= 1'b0;
    end else begin
      rx_s1   <= uart_txd_in;
      rx_s2   <= rx_s1;
      rx_d    <= rx_s2;
      rx_st   <= rx_nx;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      if (rx_nx != rx_st || rx_st == R_IDLE || tick_full) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 16'd1;
      if (rx_st == R_START) rx_bit <= '0;
      if (rx_st == R_BITS && tick_full) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
      if (rx_st == R_STOP && tick_full) begin
        if (rx_s2) begin
          rx_vld  <= 1'b1;
          rx_byte <= rx_sh;
        end else rx_ferr <= 1'b1;
      end
    end
  end

  ld_st_t      st, st_nx;
  logic [1:0]  bcnt;
  logic [31:0] asm_w, asm_nx, len, wcnt, buf_addr, buf_data;
  logic        buf_full, hs, last_b, load;

`ifdef LADYBIRD_LOADER_CSUM_EN
  localparam ld_st_t S_FIN = S_CSUM;
  logic [7:0] csum;
`else
  localparam ld_st_t S_FIN = S_DONE;
`endif

  assign asm_nx = {rx_byte, asm_w[31:8]};
  assign last_b = rx_vld && (bcnt == 2'd3);
  assign hs     = buf_full && bus_gnt;

  always_comb begin
    st_nx = st;
    case (st)
      S_LEN:
        if (last_b) begin
          if (asm_nx == '0) st_nx = S_FIN;
          else if (asm_nx > 32'(N_WORDS)) st_nx = S_ERROR;
          else st_nx = S_DATA;
        end
      // A handshake in the same cycle frees the buffer, so only a stalled buffer overruns.
      S_DATA:
        if (last_b) begin
          if (buf_full && !hs) st_nx = S_ERROR;
          else if (wcnt == len - 32'd1) st_nx = S_DRAIN;
        end
      S_DRAIN: if (!buf_full || hs) st_nx = S_FIN;
`ifdef LADYBIRD_LOADER_CSUM_EN
      S_CSUM: if (rx_vld) st_nx = (rx_byte == csum) ? S_DONE : S_ERROR;
`endif
      default: st_nx = st;
    endcase
    if (rx_ferr && st != S_DONE) st_nx = S_ERROR;
  end

  assign load = (st == S_DATA) && last_b && (st_nx != S_ERROR);

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      st <= S_LEN; bcnt <= '0; asm_w <= '0; len <= '0; wcnt <= '0;
      buf_addr <= '0; buf_data <= '0; buf_full <= 1'b0;
`ifdef LADYBIRD_LOADER_CSUM_EN
      csum <= '0;
`endif
    end else begin
      st <= st_nx;
      if (rx_vld && (st == S_LEN || st == S_DATA)) begin
        asm_w <= asm_nx;
        bcnt  <= bcnt + 2'd1;
      end
      if (st == S_LEN && last_b) len <= asm_nx;
      if (load) begin
        buf_addr <= BASE_ADDR + (wcnt << 2);
        buf_data <= asm_nx;
        wcnt     <= wcnt + 32'd1;
      end
      if (st_nx == S_ERROR) buf_full <= 1'b0;
      else if (load) buf_full <= 1'b1;
      else if (hs) buf_full <= 1'b0;
`ifdef LADYBIRD_LOADER_CSUM_EN
      if (rx_vld && st == S_DATA) csum <= csum + rx_byte;
`endif
    end
  end

  assign bus_req   = buf_full;
  assign bus_addr  = buf_addr;
  assign bus_data  = buf_data;
  assign bus_wstrb = {4{buf_full}};
  assign done      = (st == S_DONE);
  assign error     = (st == S_ERROR);
  assign core_nrst = done;
endmodule

// File: tb/tb_ladybird_uart_loader.sv
// Directed bench for ladybird_uart_loader: short bit period, bytes driven serially,
// bus writes captured by a negedge monitor.
module tb_ladybird_uart_loader;
  localparam int WT = 32;
`ifdef LADYBIRD_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0, anrst = 1'b0, uart = 1'b1;
  logic bus_req, bus_gnt, core_nrst, done, error;
  logic [31:0] bus_addr, bus_data;
  logic [3:0]  bus_wstrb;
  int gmode = 0;
  int rc = 0, cyc = 0;
  int nchk = 0, nerr = 0;

  logic        clr = 1'b1;
  int          nwr, req_cyc, run, maxrun, unstable, last_hs, done_cyc;
  logic [31:0] w_addr [8];
  logic [31:0] w_data [8];
  logic [3:0]  w_strb [8];
  logic [31:0] pa, pd;
  logic [3:0]  pw;

  ladybird_uart_loader #(.WTIME(16'(WT)), .N_WORDS(8), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .anrst(anrst), .uart_txd_in(uart),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_data(bus_data), .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt), .core_nrst(core_nrst), .done(done), .error(error));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rc <= bus_req ? rc + 1 : 0;
  assign bus_gnt = (gmode == 0) ? 1'b1 : (gmode == 1) ? (bus_req && rc == 5) : 1'b0;

  always @(negedge clk) begin
    if (clr) begin
      nwr <= 0; req_cyc <= 0; run <= 0; maxrun <= 0; unstable <= 0;
      last_hs <= -1; done_cyc <= -1;
    end else begin
      if (bus_req) begin
        req_cyc <= req_cyc + 1;
        if (run > 0 && (bus_addr !== pa || bus_data !== pd || bus_wstrb !== pw))
          unstable <= unstable + 1;
        pa <= bus_addr; pd <= bus_data; pw <= bus_wstrb;
        if (bus_gnt) begin
          if (nwr < 8) begin
            w_addr[nwr] <= bus_addr; w_data[nwr] <= bus_data; w_strb[nwr] <= bus_wstrb;
          end
          nwr <= nwr + 1;
          if (run + 1 > maxrun) maxrun <= run + 1;
          run <= 0;
          last_hs <= cyc;
        end else run <= run + 1;
      end else run <= 0;
      if (done && done_cyc < 0) done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wcyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart = 1'b0; wcyc(WT);
    for (int i = 0; i < 8; i++) begin
      uart = b[i]; wcyc(WT);
    end
    uart = stop; wcyc(WT);
    uart = 1'b1; wcyc(WT);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset(input int gm);
    clr = 1'b1; anrst = 1'b0; gmode = gm;
    wcyc(3);
    anrst = 1'b1; wcyc(1);
    clr = 1'b0; wcyc(2);
  endtask

  task automatic send_img;
    send_word(32'd2);
    send_word(32'h00100093);
    send_word(32'h00000013);
  endtask

  initial begin
    // reset state
    gmode = 0; anrst = 1'b0; wcyc(3);
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_data", bus_data, 0);
    chk("rst_wstrb", 32'(bus_wstrb), 0);
    chk("rst_core_nrst", 32'(core_nrst), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);

    // scenario 1: two words, gnt tied high
    do_reset(0);
    send_img();
    chk("s1_done_early", 32'(done), 32'(!CSUM));
    if (CSUM) send_byte(8'hB6, 1'b1);
    wcyc(4);
    chk("s1_nwr", nwr, 2);
    chk("s1_addr0", w_addr[0], 32'h0);
    chk("s1_data0", w_data[0], 32'h00100093);
    chk("s1_addr1", w_addr[1], 32'h4);
    chk("s1_data1", w_data[1], 32'h00000013);
    chk("s1_wstrb", 32'(w_strb[0] & w_strb[1]), 32'hf);
    chk("s1_done", 32'(done), 1);
    chk("s1_core_nrst", 32'(core_nrst), 1);
    chk("s1_error", 32'(error), 0);
`ifndef LADYBIRD_LOADER_CSUM_EN
    chk("s1_done_delay", done_cyc - last_hs, 1);
`endif

    // scenario 2: grant delayed 5 cycles per request
    do_reset(1);
    send_img();
    if (CSUM) send_byte(8'hB6, 1'b1);
    wcyc(4);
    chk("s2_nwr", nwr, 2);
    chk("s2_req_len", maxrun, 6);
    chk("s2_req_cycles", req_cyc, 12);
    chk("s2_unstable", unstable, 0);
    chk("s2_data1", w_data[1], 32'h00000013);
    chk("s2_done", 32'(done), 1);

    // L = 0
    do_reset(0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    chk("l0_done_3b", 32'(done), 0);
    send_byte(8'h00, 1'b1);
    if (CSUM) send_byte(8'h00, 1'b1);
    chk("l0_done", 32'(done), 1);
    chk("l0_no_req", req_cyc, 0);

    // L = 9 exceeds N_WORDS
    do_reset(0);
    send_word(32'd9);
    wcyc(WT * 10);
    chk("l9_error", 32'(error), 1);
    chk("l9_core_nrst", 32'(core_nrst), 0);
    chk("l9_no_req", req_cyc, 0);

    // framing error on 2nd length byte
    do_reset(0);
    send_byte(8'h01, 1'b1);
    chk("fe_error_pre", 32'(error), 0);
    send_byte(8'h00, 1'b0);
    chk("fe_error", 32'(error), 1);

    // 2-cycle glitch on idle line, then a clean L = 0
    do_reset(0);
    uart = 1'b0; wcyc(2); uart = 1'b1; wcyc(WT * 3);
    chk("gl_error", 32'(error), 0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    chk("gl_done_3b", 32'(done), 0);
    send_byte(8'h00, 1'b1);
    if (CSUM) send_byte(8'h00, 1'b1);
    chk("gl_done", 32'(done), 1);
    chk("gl_error2", 32'(error), 0);

    // overrun: grant never given, second word completes with buffer full
    do_reset(2);
    send_word(32'd2);
    send_word(32'h00100093);
    chk("ov_req_pending", 32'(bus_req), 1);
    send_word(32'h00000013);
    wcyc(2);
    chk("ov_error", 32'(error), 1);
    chk("ov_req", 32'(bus_req), 0);
    chk("ov_core_nrst", 32'(core_nrst), 0);

    // asynchronous reset with a write pending mid-word
    do_reset(2);
    send_word(32'd2);
    send_word(32'h00100093);
    send_byte(8'h13, 1'b1);
    chk("ar_addr_pre", bus_addr, 32'h0);
    chk("ar_data_pre", bus_data, 32'h00100093);
    uart = 1'b0; wcyc(WT * 3);
    #3 anrst = 1'b0;
    #1;
    chk("ar_req", 32'(bus_req), 0);
    chk("ar_data", bus_data, 0);
    chk("ar_wstrb", 32'(bus_wstrb), 0);
    chk("ar_done_err", {30'd0, done, error}, 0);
    uart = 1'b1;

`ifdef LADYBIRD_LOADER_CSUM_EN
    // bad checksum
    do_reset(0);
    send_img();
    send_byte(8'hB5, 1'b1);
    wcyc(4);
    chk("cs_bad_error", 32'(error), 1);
    chk("cs_bad_core_nrst", 32'(core_nrst), 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
